// File: rtl/sc_pkg.sv
// Shared stochastic-computing definitions: word width, decoder state codes and
// a constant-evaluable ceil(log2) used for sizing counters and result buses.
package sc_pkg;

   localparam int SC_WORD_W = 16;

   typedef logic [0:0] sc_dec_state_t;
   localparam sc_dec_state_t DEC_ACCUM = 1'b0;
   localparam sc_dec_state_t DEC_HOLD  = 1'b1;

   // ceil(log2(value)); sc_clog2(1) == 0, sc_clog2(0) == 0
   function automatic int sc_clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/sc_popcount.sv
// Combinational population count built as a balanced binary adder tree.
// The input is zero-padded up to the next power of two; each level halves the node count.
module sc_popcount
   import sc_pkg::*;
#(
   parameter int IN_WIDTH = SC_WORD_W,
   parameter int CNT_W    = sc_clog2(IN_WIDTH + 1)
) (
   input  logic [IN_WIDTH-1:0] i_bits,
   output logic [CNT_W-1:0]    o_count
);

   localparam int LEVELS = sc_clog2(IN_WIDTH);
   localparam int NP     = 1 << LEVELS;

   genvar gi, gj;
   generate
      for (gi = 0; gi <= LEVELS; gi++) begin : g_lvl
         logic [CNT_W-1:0] w_sum [NP >> gi];
         for (gj = 0; gj < (NP >> gi); gj++) begin : g_node
            if (gi == 0) begin : g_leaf
               if (gj < IN_WIDTH) begin : g_bit
                  assign w_sum[gj] = CNT_W'(i_bits[gj]);
               end else begin : g_pad
                  assign w_sum[gj] = '0;
               end
            end else begin : g_add
               // every partial sum is bounded by IN_WIDTH, so CNT_W never overflows
               assign w_sum[gj] = g_lvl[gi-1].w_sum[2*gj] + g_lvl[gi-1].w_sum[2*gj+1];
            end
         end
      end
   endgenerate

   assign o_count = g_lvl[LEVELS].w_sum[0];

endmodule

// File: rtl/sc_bitstream_decoder.sv
// Stochastic-to-binary decoder: sums the ones of FRAME_WORDS stochastic words and
// holds the frame result behind a valid/ready handshake. Define SC_DEC_BIPOLAR_EN for 2*count-N output.
module sc_bitstream_decoder
   import sc_pkg::*;
#(
   parameter int IN_WIDTH    = SC_WORD_W,
   parameter int FRAME_WORDS = 4,
   parameter int OUT_WIDTH   = 7
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [IN_WIDTH-1:0] in_bits,
   output logic                out_valid,
   input  logic                out_ready,
`ifdef SC_DEC_BIPOLAR_EN
   output logic [OUT_WIDTH:0]  out_count
`else
   output logic [OUT_WIDTH-1:0] out_count
`endif
);

   localparam int PC_W   = sc_clog2(IN_WIDTH + 1);
   localparam int CNT_W  = (FRAME_WORDS > 1) ? sc_clog2(FRAME_WORDS) : 1;
   localparam int N_BITS = IN_WIDTH * FRAME_WORDS;

   generate
      if (FRAME_WORDS < 1 || FRAME_WORDS > 256) begin : g_bad_frame
         $error("sc_bitstream_decoder: FRAME_WORDS must be within 1..256");
      end
      if (OUT_WIDTH < sc_clog2(N_BITS + 1)) begin : g_bad_width
         $error("sc_bitstream_decoder: OUT_WIDTH too narrow for IN_WIDTH*FRAME_WORDS");
      end
   endgenerate

   sc_dec_state_t        r_state;
   logic [OUT_WIDTH-1:0] r_acc;
   logic [CNT_W-1:0]     r_word_cnt;
   logic                 r_rst_done;
   logic                 r_out_valid;
`ifdef SC_DEC_BIPOLAR_EN
   logic [OUT_WIDTH:0]   r_out_count;
   logic [OUT_WIDTH:0]   w_result;
`else
   logic [OUT_WIDTH-1:0] r_out_count;
   logic [OUT_WIDTH-1:0] w_result;
`endif

   logic [PC_W-1:0]      w_pc;
   logic [OUT_WIDTH-1:0] w_sum;
   logic                 w_in_ready;
   logic                 w_accept;
   logic                 w_last;

   sc_popcount #(
      .IN_WIDTH (IN_WIDTH),
      .CNT_W    (PC_W)
   ) u_popcount (
      .i_bits  (in_bits),
      .o_count (w_pc)
   );

   // in_ready stays low while reset is held and rises on the first edge after release
   assign w_in_ready = r_rst_done && (r_state == DEC_ACCUM);
   assign w_accept   = in_valid && w_in_ready;
   assign w_last     = (r_word_cnt == CNT_W'(FRAME_WORDS - 1));
   assign w_sum      = r_acc + OUT_WIDTH'(w_pc);

`ifdef SC_DEC_BIPOLAR_EN
   assign w_result = {w_sum, 1'b0} - (OUT_WIDTH + 1)'(N_BITS);
`else
   assign w_result = w_sum;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= DEC_ACCUM;
         r_acc       <= '0;
         r_word_cnt  <= '0;
         r_rst_done  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_count <= '0;
      end else begin
         r_rst_done <= 1'b1;
         if (clr) begin
            r_state     <= DEC_ACCUM;
            r_acc       <= '0;
            r_word_cnt  <= '0;
            r_out_valid <= 1'b0;
         end else begin
            case (r_state)
               DEC_ACCUM: begin
                  if (w_accept) begin
                     if (w_last) begin
                        r_out_count <= w_result;
                        r_out_valid <= 1'b1;
                        r_acc       <= '0;
                        r_word_cnt  <= '0;
                        r_state     <= DEC_HOLD;
                     end else begin
                        r_acc      <= w_sum;
                        r_word_cnt <= r_word_cnt + CNT_W'(1);
                     end
                  end
               end
               default: begin
                  if (out_ready) begin
                     r_out_valid <= 1'b0;
                     r_state     <= DEC_ACCUM;
                  end
               end
            endcase
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign out_count = r_out_count;

endmodule

// File: tb/tb_sc_bitstream_decoder.sv
// Self-checking bench for sc_bitstream_decoder: directed frames plus randomized traffic,
// compared every cycle against a frame-level reference model (word list sums via $countones).
module tb_sc_bitstream_decoder;

   localparam int IN_W = 16;
   localparam int FW   = 4;
`ifdef SC_DEC_BIPOLAR_EN
   localparam int OUT_W = 8;
`else
   localparam int OUT_W = 7;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             clr = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [IN_W-1:0]  in_bits = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [OUT_W-1:0] out_count;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   bit               m_started = 0;
   bit               m_pending = 0;
   int               m_cnt = 0;
   int               m_sum = 0;
   logic [OUT_W-1:0] m_exp = '0;

   sc_bitstream_decoder #(
      .IN_WIDTH    (IN_W),
      .FRAME_WORDS (FW),
      .OUT_WIDTH   (7)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bits   (in_bits),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [OUT_W-1:0] ref_result(input int ones);
      int v;
`ifdef SC_DEC_BIPOLAR_EN
      v = 2 * ones - IN_W * FW;
`else
      v = ones;
`endif
      return OUT_W'(v);
   endfunction

   task automatic model_reset();
      m_started = 0;
      m_pending = 0;
      m_cnt     = 0;
      m_sum     = 0;
      m_exp     = '0;
   endtask

   // applies the inputs that were present at the rising edge just taken
   task automatic model_edge();
      bit ready;
      ready = m_started && !m_pending;
      if (clr) begin
         m_cnt = 0;
         m_sum = 0;
         m_pending = 0;
      end else if (m_pending) begin
         if (out_ready) begin
            $display("result handshake: out_count=%0d (0x%0h)", $signed(m_exp), m_exp);
            m_pending = 0;
         end
      end else if (in_valid && ready) begin
         m_sum += $countones(in_bits);
         m_cnt++;
         if (m_cnt == FW) begin
            m_exp     = ref_result(m_sum);
            m_pending = 1;
            m_cnt     = 0;
            m_sum     = 0;
         end
      end
      m_started = 1;
   endtask

   // called at a falling edge: check outputs, drive inputs, take one rising edge
   task automatic cycle(input logic v, input logic [IN_W-1:0] b, input logic r, input logic c);
      check_eq("in_ready", in_ready, m_started && !m_pending);
      check_eq("out_valid", out_valid, m_pending);
      check_eq("out_count", out_count, m_exp);
      in_valid  = v;
      in_bits   = b;
      out_ready = r;
      clr       = c;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic frame(input logic [IN_W-1:0] b);
      for (int i = 0; i < FW; i++) cycle(1'b1, b, 1'b1, 1'b0);
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_out_count", out_count, '0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_eq("reset_out_valid", out_valid, 1'b0);
      check_eq("reset_out_count", out_count, '0);
      rst_n = 1'b1;
      cycle(1'b0, '0, 1'b1, 1'b0);

      // back-to-back frames with downstream always ready
      frame(16'hFFFF);
      cycle(1'b0, '0, 1'b1, 1'b0);
      frame(16'h0099);
      cycle(1'b0, '0, 1'b1, 1'b0);
      frame(16'h0000);
      cycle(1'b0, '0, 1'b1, 1'b0);

      // downstream stalls for 5 cycles while the result is held
      for (int i = 0; i < FW; i++) cycle(1'b1, 16'h1234, 1'b0, 1'b0);
      repeat (5) cycle(1'b1, 16'hFFFF, 1'b0, 1'b0);
      cycle(1'b1, 16'hFFFF, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);

      // partial frame aborted by clr; the word presented with clr is dropped
      cycle(1'b1, 16'hFFFF, 1'b1, 1'b0);
      cycle(1'b1, 16'hFFFF, 1'b1, 1'b0);
      cycle(1'b1, 16'hFFFF, 1'b1, 1'b1);
      frame(16'h000F);
      cycle(1'b0, '0, 1'b1, 1'b0);

      // clr while a result is held
      for (int i = 0; i < FW; i++) cycle(1'b1, 16'h00FF, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b1);
      cycle(1'b0, '0, 1'b1, 1'b0);

      // async reset mid-frame, then mid-HOLD
      cycle(1'b1, 16'hFFFF, 1'b1, 1'b0);
      cycle(1'b1, 16'hFFFF, 1'b1, 1'b0);
      async_reset();
      cycle(1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < FW; i++) cycle(1'b1, 16'hAAAA, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0);
      async_reset();
      repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);
      frame(16'h0001);
      cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);

      // randomized traffic with gaps, stalls and occasional aborts
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(99) < 70, IN_W'($urandom), $urandom_range(99) < 60,
               $urandom_range(99) < 3);
      end
      cycle(1'b0, '0, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sc_bitstream_decoder.md
Name: sc_bitstream_decoder

Overview:
Stochastic-to-binary converter: the decode end of the stochastic datapath. It consumes parallel stochastic bitstream words, such as the AND-product words from the Sobol encoder/multiplier stage. It counts the ones over a frame of FRAME_WORDS words and emits the binary count with a valid/ready handshake. It sits at the SC-to-binary boundary, feeding binary results back to the CGRA PE datapath.

Parameters:
IN_WIDTH, 16, bits per stochastic word (one parallel bitstream slice per cycle)
FRAME_WORDS, 4, words accumulated per result; legal range 1..256
OUT_WIDTH, 7, result width; must be >= clog2(IN_WIDTH*FRAME_WORDS+1); elaboration error otherwise

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
clr  in  1  synchronous abort: drops the partial frame and any held result
in_valid  in  1  in_bits valid
in_ready  out  1  decoder accepts a word this cycle
in_bits  in  IN_WIDTH  stochastic word
out_valid  out  1  out_count valid
out_ready  in  1  downstream accepts the result
out_count  out  OUT_WIDTH  ones count of the completed frame, unsigned

Behaviour:
- Clock and reset: one clock (clk); rst_n is asynchronous, active-low.
- Reset values (asserted asynchronously): state=ACCUM, acc=0, word_cnt=0, out_valid=0, out_count=0. in_ready=1 from the first edge after release.
- State ACCUM:
  - in_ready=1.
  - On in_valid&in_ready: acc += popcount(in_bits) and word_cnt++.
  - On the accept where word_cnt==FRAME_WORDS-1: out_count <= acc+popcount(in_bits), out_valid <= 1, acc <= 0, word_cnt <= 0, next state HOLD.
- State HOLD:
  - in_ready=0.
  - out_valid=1, and out_count is held stable until out_valid&out_ready.
  - On handshake: out_valid <= 0 next cycle, next state ACCUM.
- Latency: result is visible one cycle after the last word is accepted.
- Throughput: FRAME_WORDS+1 cycles per frame when in_valid and out_ready are held high.
- in_valid low in ACCUM: no change; gaps inside a frame are allowed.
- FRAME_WORDS=1: every accepted word produces a result.
- Width rules:
  - acc is OUT_WIDTH bits wide and can never overflow, given the parameter check.
  - popcount is zero-extended to OUT_WIDTH.
- clr: highest priority, but below rst_n. Next cycle it forces state=ACCUM, acc=0, word_cnt=0, out_valid=0. out_count keeps its last value but is invalid. A word presented in the same cycle as clr is dropped.
- Reset mid-frame or mid-HOLD: everything returns to the reset values immediately; the partial result is lost.
- out_ready while out_valid=0 is ignored.

Optional Feature:
- Macro: SC_DEC_BIPOLAR_EN.
- Defined: bipolar decoding.
  - out_count becomes OUT_WIDTH+1 bits, two's complement.
  - Value = 2*count - IN_WIDTH*FRAME_WORDS, range [-N, +N].
  - It is computed in the final accept cycle, so latency is unchanged.
- Undefined: unipolar unsigned count, OUT_WIDTH bits, as specified above.

Decomposition:
- Shared package sc_pkg:
  - SC_WORD_W=16.
  - Decoder state enum {ACCUM, HOLD}.
  - clog2 function used for the OUT_WIDTH check and the word_cnt width.
- One sub-module: sc_popcount, parameterised IN_WIDTH.
  - Purely combinational adder tree.
  - Output width clog2(IN_WIDTH+1).
  - Reusable by other SC stages.

Test Plan:
- Reset, then 4 words of 16'hFFFF with in_valid high and out_ready high -> out_valid pulses 1 cycle after the 4th accept, out_count=64; in_ready=0 for exactly 1 cycle.
- 4 words of 16'h0099 (encoder product for a=16, b=16, popcount 4 each) -> out_count=16. Then 4 words of 16'h0000 -> out_count=0.
- Complete a frame with out_ready held low 5 cycles -> out_valid stays 1, out_count stable, in_ready=0 throughout. Raise out_ready -> handshake, then in_ready=1 next cycle.
- 2 words of 16'hFFFF, then clr for 1 cycle, then 4 words of 16'h000F -> out_count=16 (partial frame discarded).
- rst_n pulled low asynchronously mid-frame and mid-HOLD -> out_valid drops immediately, no spurious result after release. The next frame of 16'h0001 x4 gives 4.
- With SC_DEC_BIPOLAR_EN defined:
  - all-ones frame -> +64
  - all-zeros frame -> -64 (8'hC0)
  - 16'h00FF x4 -> 0
